// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit and its memory map.
// Latency: none (types, constants and a combinational helper function).
// Backpressure: not applicable.
package lsu_pkg;

  // Access size encodings on size_i
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_R = 2'd3;  // reserved, always an error

  // Default address map
  localparam logic [31:0] DEF_IO_OUT_BASE = 32'h0000_0800;
  localparam logic [31:0] DEF_IO_IN_BASE  = 32'h0000_0900;

  typedef enum logic [1:0] {
    REG_DMEM = 2'd0,
    REG_OUT  = 2'd1,
    REG_IN   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // Pull the addressed lane out of a 32-bit word, move it to bit 0 and
  // sign- or zero-extend it. Word accesses return the word unchanged.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_sync2.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous inputs.
// Latency: 2 clk_i edges from input change to q_o.
// Backpressure: none; samples every cycle.
module lsu_sync2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability-settling chain; both stages clear on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit: data RAM, memory-mapped output registers and synchronised switch input.
// Latency: loads return data and ld_valid_o one cycle after req_i; stores commit at the request edge.
// Backpressure: none; accepts one request every cycle.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH  = 512,
  parameter int unsigned NUM_HEX     = 8,
  parameter logic [31:0] IO_OUT_BASE = DEF_IO_OUT_BASE,
  parameter logic [31:0] IO_IN_BASE  = DEF_IO_IN_BASE,
  parameter int unsigned SW_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           st_data_i,
  input  logic [SW_W-1:0]       io_sw_i,
  output logic [31:0]           ld_data_o,
  output logic                  ld_valid_o,
  output logic                  err_o,
  output logic [NUM_HEX*32-1:0] io_hex_o,
  output logic [31:0]           io_ledr_o,
  output logic [31:0]           io_ledg_o,
  output logic [31:0]           io_lcd_o
);

  localparam int unsigned NUM_OUT = NUM_HEX + 3;
  localparam int unsigned AW      = $clog2(DMEM_DEPTH);
  localparam int unsigned SLW     = $clog2(NUM_OUT);

  logic [31:0]     mem_q [DMEM_DEPTH];
  logic [31:0]     out_q [NUM_OUT];
  logic [SW_W-1:0] sw_sync;
  logic [31:0]     sw_word;

  logic [31:0]     waddr;
  logic [31:0]     off;
  logic [SLW-1:0]  slot;
  region_e         region;
  logic            misalign;
  logic            acc_err;
  logic            wr_en;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rd_word;

  logic [31:0]     ld_data_q, ld_data_d;
  logic            ld_valid_q, ld_valid_d;
  logic            err_q, err_d;

  lsu_sync2 #(.W(SW_W)) u_sw_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (io_sw_i),
    .q_o    (sw_sync)
  );

  // Zero-extend the switch bank to a full word
  always_comb begin
    sw_word             = '0;
    sw_word[SW_W-1:0]   = sw_sync;
  end

  // Address decode and error classification on the word address
  always_comb begin
    waddr  = {addr_i[31:2], 2'b00};
    off    = waddr - IO_OUT_BASE;
    slot   = off[4 +: SLW];
    region = REG_NONE;
    if (waddr < 32'(DMEM_DEPTH * 4)) begin
      region = REG_DMEM;
    end else if (waddr >= IO_OUT_BASE && off < 32'(NUM_OUT * 16) && off[3:2] == 2'b00) begin
      region = REG_OUT;
    end else if (waddr == IO_IN_BASE) begin
      region = REG_IN;
    end
    misalign = (size_i == SZ_H && addr_i[0]) || (size_i == SZ_W && addr_i[1:0] != 2'b00);
    acc_err  = (size_i == SZ_R) || misalign || (region == REG_NONE) ||
               (we_i && region == REG_IN);
    wr_en    = req_i && we_i && !acc_err;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = st_data_i;
    case (size_i)
      SZ_B: begin
        be    = 4'b0001 << addr_i[1:0];
        wdata = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data_i[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Data RAM: byte-lane writes, contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_en && region == REG_DMEM) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[waddr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Output register file: byte-lane writes, cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else if (wr_en && region == REG_OUT) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) out_q[slot][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read mux and next-state for the load/error result registers
  always_comb begin
    rd_word = '0;
    case (region)
      REG_DMEM: rd_word = mem_q[waddr[AW+1:2]];
      REG_OUT:  rd_word = out_q[slot];
      REG_IN:   rd_word = sw_word;
      default:  rd_word = '0;
    endcase
    ld_valid_d = req_i && !we_i;
    err_d      = req_i && acc_err;
    ld_data_d  = ld_data_q;
    if (req_i && !we_i) begin
      ld_data_d = acc_err ? 32'h0 : lane_extend(rd_word, addr_i[1:0], size_i, unsigned_i);
    end
  end

  // Load result and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      err_q      <= err_d;
    end
  end

  assign ld_data_o  = ld_data_q;
  assign ld_valid_o = ld_valid_q;
  assign err_o      = err_q;

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = out_q[g];
  end
  assign io_ledr_o = out_q[NUM_HEX];
  assign io_ledg_o = out_q[NUM_HEX+1];
  assign io_lcd_o  = out_q[NUM_HEX+2];

endmodule

// File: tb/tb_lsu_mmio.sv
// Bench for lsu_mmio: directed steps plus randomized traffic against a byte-addressed model.
// Latency: expects load results one cycle after each request.
// Backpressure: none; issues back-to-back requests.
module tb_lsu_mmio;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_i, we_i, unsigned_i;
  logic [1:0]   size_i;
  logic [31:0]  addr_i, st_data_i, io_sw_i;
  logic [31:0]  ld_data_o, io_ledr_o, io_ledg_o, io_lcd_o;
  logic         ld_valid_o, err_o;
  logic [255:0] io_hex_o;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  model_b [int unsigned];
  logic [31:0] exp_ld;
  logic [31:0] sw_cur, sw_old;
  int          cyc, sw_chg;

  lsu_mmio dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
    .st_data_i(st_data_i), .io_sw_i(io_sw_i), .ld_data_o(ld_data_o),
    .ld_valid_o(ld_valid_o), .err_o(err_o), .io_hex_o(io_hex_o),
    .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = dmem, 1 = out, 2 = in, 3 = unmapped
  function automatic int region_of(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 32'd2048) return 0;
    if (w >= 32'h800 && w < 32'h800 + 11 * 16 && (w - 32'h800) % 16 == 0) return 1;
    if (w == 32'h900) return 2;
    return 3;
  endfunction

  function automatic logic is_err(input logic we, input logic [1:0] sz, input logic [31:0] a);
    int r;
    r = region_of(a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a % 2 != 0) return 1'b1;
    if (sz == 2'd2 && a % 4 != 0) return 1'b1;
    if (r == 3) return 1'b1;
    if (we && r == 2) return 1'b1;
    return 1'b0;
  endfunction

  // switch value visible to a load requested in the current cycle
  function automatic logic [31:0] sw_seen();
    return (cyc - sw_chg >= 2) ? sw_cur : sw_old;
  endfunction

  function automatic logic [7:0] gb(input logic [31:0] a);
    logic [31:0] s;
    if ((a & 32'hFFFF_FFFC) == 32'h900) begin
      s = sw_seen() >> (8 * (a % 4));
      return s[7:0];
    end
    if (model_b.exists(a)) return model_b[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {gb(a + 3), gb(a + 2), gb(a + 1), gb(a)};
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        b = gb(a);
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = {gb(a + 1), gb(a)};
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return word_at(a);
    endcase
  endfunction

  task automatic check_io(input string tag);
    logic [255:0] hx;
    for (int k = 0; k < 8; k++) hx[32*k +: 32] = word_at(32'h800 + 32'(16 * k));
    chk({tag, ".hex"}, io_hex_o, hx);
    chk({tag, ".ledr"}, {224'h0, io_ledr_o}, {224'h0, word_at(32'h880)});
    chk({tag, ".ledg"}, {224'h0, io_ledg_o}, {224'h0, word_at(32'h890)});
    chk({tag, ".lcd"}, {224'h0, io_lcd_o}, {224'h0, word_at(32'h8A0)});
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [31:0] v;
    int          nb;
    e = is_err(we, sz, a);
    v = (!we && !e) ? load_val(a, sz, uns) : 32'h0;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; st_data_i = d;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    if (we && !e) begin
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) model_b[a + 32'(i)] = d[8*i +: 8];
    end
    if (!we) exp_ld = v;
    chk({tag, ".err"}, {255'h0, err_o}, {255'h0, e});
    chk({tag, ".vld"}, {255'h0, ld_valid_o}, {255'h0, !we});
    chk({tag, ".data"}, {224'h0, ld_data_o}, {224'h0, exp_ld});
    check_io(tag);
  endtask

  task automatic idle(input string tag);
    req_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    chk({tag, ".vld"}, {255'h0, ld_valid_o}, 256'h0);
    chk({tag, ".err"}, {255'h0, err_o}, 256'h0);
    chk({tag, ".data"}, {224'h0, ld_data_o}, {224'h0, exp_ld});
  endtask

  task automatic model_reset();
    for (int unsigned x = 32'h800; x < 32'h8B0; x++) model_b.delete(x);
    exp_ld = 32'h0;
  endtask

  task automatic set_sw(input logic [31:0] v);
    sw_old  = sw_seen();
    sw_cur  = v;
    sw_chg  = cyc;
    io_sw_i = v;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        we;
    int          cls;

    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = 32'h0; st_data_i = 32'h0; io_sw_i = 32'h0;
    cyc = 0; sw_chg = 0; sw_cur = 32'h0; sw_old = 32'h0; exp_ld = 32'h0;
    #12;
    chk("rst.vld", {255'h0, ld_valid_o}, 256'h0);
    chk("rst.err", {255'h0, err_o}, 256'h0);
    chk("rst.data", {224'h0, ld_data_o}, 256'h0);
    check_io("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    sw_chg = cyc;

    op("ld800", 1'b0, 2'd2, 1'b0, 32'h800, 32'h0);

    // initialise the low DMEM window and the top word
    for (int i = 0; i < 64; i++) op("init", 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
    op("top_sw", 1'b1, 2'd2, 1'b0, 32'h7FC, 32'hCAFE_F00D);
    op("top_lw", 1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0);

    // word and sub-word paths
    op("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    op("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("lw40.literal", {224'h0, ld_data_o}, {224'h0, 32'h1234_5678});
    op("sb41", 1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AB);
    op("lw40b", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("lw40b.literal", {224'h0, ld_data_o}, {224'h0, 32'h1234_AB78});
    op("lb41", 1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
    chk("lb41.literal", {224'h0, ld_data_o}, {224'h0, 32'hFFFF_FFAB});
    op("lbu41", 1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
    chk("lbu41.literal", {224'h0, ld_data_o}, {224'h0, 32'h0000_00AB});
    op("lh42", 1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
    chk("lh42.literal", {224'h0, ld_data_o}, {224'h0, 32'h0000_1234});

    // I/O outputs
    op("sw830", 1'b1, 2'd2, 1'b0, 32'h830, 32'hDEAD_BEEF);
    chk("hex3.literal", {224'h0, io_hex_o[127:96]}, {224'h0, 32'hDEAD_BEEF});
    op("lw830", 1'b0, 2'd2, 1'b0, 32'h830, 32'h0);
    op("sh892", 1'b1, 2'd1, 1'b0, 32'h892, 32'h0000_55AA);
    chk("ledg.literal", {224'h0, io_ledg_o}, {224'h0, 32'h55AA_0000});
    op("sb880", 1'b1, 2'd0, 1'b0, 32'h883, 32'h0000_0081);
    op("sw8a0", 1'b1, 2'd2, 1'b0, 32'h8A0, 32'h0BAD_CAFE);

    // switch synchroniser
    set_sw(32'h3FF);
    idle("sw_wait");
    op("sw_early", 1'b0, 2'd2, 1'b0, 32'h900, 32'h0);
    op("sw_late", 1'b0, 2'd2, 1'b0, 32'h900, 32'h0);
    chk("sw_late.literal", {224'h0, ld_data_o}, {224'h0, 32'h0000_03FF});

    // errors
    op("e_mis", 1'b1, 2'd2, 1'b0, 32'h42, 32'hFFFF_FFFF);
    op("e_slot", 1'b0, 2'd2, 1'b0, 32'h804, 32'h0);
    op("e_in_st", 1'b1, 2'd2, 1'b0, 32'h900, 32'h1111_1111);
    op("e_sz3", 1'b1, 2'd3, 1'b0, 32'h44, 32'h2222_2222);
    op("e_8b0", 1'b1, 2'd2, 1'b0, 32'h8B0, 32'h3333_3333);
    op("e_mis_h", 1'b0, 2'd1, 1'b0, 32'h893, 32'h0);
    op("lw900", 1'b0, 2'd2, 1'b0, 32'h900, 32'h0);
    idle("idle1");

    // reset during an in-flight load
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h830;
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    req_i = 1'b0;
    model_reset();
    chk("mid_rst.vld", {255'h0, ld_valid_o}, 256'h0);
    chk("mid_rst.err", {255'h0, err_o}, 256'h0);
    chk("mid_rst.data", {224'h0, ld_data_o}, 256'h0);
    check_io("mid_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    sw_old = 32'h0;
    sw_chg = cyc;
    op("post_rst", 1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
    op("post_rst_sw", 1'b0, 2'd2, 1'b0, 32'h900, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0 && cyc - sw_chg >= 2) set_sw($urandom);
      cls = $urandom_range(0, 9);
      if (cls < 5) a = 32'($urandom_range(0, 255));
      else if (cls < 8) a = 32'h800 + 32'(16 * $urandom_range(0, 10)) +
                            (($urandom_range(0, 7) == 0) ? 32'(4 * $urandom_range(1, 3)) : 32'h0) +
                            32'($urandom_range(0, 3));
      else if (cls < 9) a = 32'h900 + 32'($urandom_range(0, 3));
      else a = 32'h8B0 + 32'($urandom_range(0, 4095));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if ($urandom_range(0, 7) == 0) idle("r_idle");
      else op("rnd", we, sz, 1'($urandom_range(0, 1)), a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
